// File: rtl/dp1m4_pkg.sv
// dp1m4_pkg: shared definitions for the sparse 1-of-4 row sequencer.
//   - state_t      : sequencer state encoding
//   - BW_DEF/NNZ_DEF/TOTAL_DEF : default element width, nonzeros per load, mask width
//   - IDX_W        : width of one activation index (two indices per pair)
//   - sat_inc32    : saturating 32-bit increment used by the optional perf counters
package dp1m4_pkg;

    localparam int BW_DEF    = 4;
    localparam int NNZ_DEF   = 8;
    localparam int TOTAL_DEF = 16;
    localparam int IDX_W     = 2;

    typedef enum logic [2:0] {
        IDLE,
        WREQ,
        LWAIT,
        EXEC,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dp1m4_row_sched_if.sv
// dp1m4_row_sched_if: command, weight stream, activation stream and row-side
// signals of the row sequencer.
//   slave  : the sequencer side (consumes command/streams, drives row controls)
//   master : the surrounding buffers/row side
// Optional DP1M4_ROW_SCHED_PERF_EN adds stall_cnt/run_cnt (driven by the sequencer).
interface dp1m4_row_sched_if
    import dp1m4_pkg::*;
#(
    parameter int bw    = BW_DEF,
    parameter int nnz   = NNZ_DEF,
    parameter int total = TOTAL_DEF,
    parameter int cnt_w = 16
) ();

    logic                  start;
    logic [cnt_w-1:0]      num_pairs;
    logic                  w_valid;
    logic                  w_ready;
    logic [nnz*bw-1:0]     w_data;
    logic [total-1:0]      w_mask;
    logic                  a_valid;
    logic                  a_ready;
    logic [2*bw-1:0]       a_data;
    logic [2*IDX_W-1:0]    a_index;
    logic [nnz*bw-1:0]     weights_flat;
    logic [total-1:0]      weight_mask;
    logic [2*bw-1:0]       activation_flat;
    logic [2*IDX_W-1:0]    activation_index_flat;
    logic                  load;
    logic                  execute;
    logic                  a_select;
    logic                  psum_valid;
    logic                  busy;
    logic                  done;
`ifdef DP1M4_ROW_SCHED_PERF_EN
    logic [31:0]           stall_cnt;
    logic [31:0]           run_cnt;
`endif

    modport slave (
        input  start, num_pairs, w_valid, w_data, w_mask, a_valid, a_data, a_index,
        output w_ready, a_ready, weights_flat, weight_mask, activation_flat,
               activation_index_flat, load, execute, a_select, psum_valid, busy, done
`ifdef DP1M4_ROW_SCHED_PERF_EN
        , output stall_cnt, run_cnt
`endif
    );

    modport master (
        output start, num_pairs, w_valid, w_data, w_mask, a_valid, a_data, a_index,
        input  w_ready, a_ready, weights_flat, weight_mask, activation_flat,
               activation_index_flat, load, execute, a_select, psum_valid, busy, done
`ifdef DP1M4_ROW_SCHED_PERF_EN
        , input stall_cnt, run_cnt
`endif
    );

endinterface

// File: rtl/dp1m4_vdelay.sv
// dp1m4_vdelay: single-bit delay line of DEPTH flops with async active-low clear.
//   clk   : clock
//   reset : async active-low clear of every stage
//   i_d   : bit entering the line
//   o_q   : i_d delayed by DEPTH cycles (DEPTH=0 is a plain wire)
module dp1m4_vdelay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign o_q = i_d;
        end else begin : g_shift
            logic [DEPTH-1:0] r_sr;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_sr <= '0;
                end else begin
                    r_sr[0] <= i_d;
                    for (int unsigned k = 1; k < DEPTH; k++) begin
                        r_sr[k] <= r_sr[k-1];
                    end
                end
            end

            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dp1m4_row_sched.sv
// dp1m4_row_sched: sequencer for one sparse 1-of-4 dot-product row.
// Accepts a start command, pulls one compressed weight word, pulses load and
// waits ld_lat cycles, streams num_pairs activation pairs with execute, drains
// exe_lat cycles and pulses done. psum_valid is execute delayed by exe_lat.
//   clk   : clock
//   reset : async active-low reset
//   bus   : dp1m4_row_sched_if.slave (start/num_pairs, weight stream, activation
//           stream, registered row outputs, load/execute/a_select/psum_valid,
//           busy/done)
// Optional feature macro: DP1M4_ROW_SCHED_PERF_EN adds stall_cnt/run_cnt.
module dp1m4_row_sched
    import dp1m4_pkg::*;
#(
    parameter int bw      = BW_DEF,
    parameter int nnz     = NNZ_DEF,
    parameter int total   = TOTAL_DEF,
    parameter int cnt_w   = 16,
    parameter int exe_lat = 3,
    parameter int ld_lat  = 2
) (
    input  logic               clk,
    input  logic               reset,
    dp1m4_row_sched_if.slave   bus
);

    localparam int MAX_LAT = (exe_lat > ld_lat) ? exe_lat : ld_lat;
    localparam int TMR_W   = $clog2(MAX_LAT + 2);

    state_t                r_state;
    state_t                w_next;
    logic [cnt_w-1:0]      r_num_pairs;
    logic [cnt_w-1:0]      r_beat;
    logic [TMR_W-1:0]      r_tmr;
    logic [nnz*bw-1:0]     r_weights;
    logic [total-1:0]      r_mask;
    logic [2*bw-1:0]       r_act;
    logic [2*IDX_W-1:0]    r_idx;
    logic                  r_load;
    logic                  r_execute;
    logic                  r_a_select;
    logic                  w_psum_valid;

    logic                  w_w_ready;
    logic                  w_a_ready;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_start_acc;
    logic                  w_w_acc;
    logic                  w_a_acc;
    logic                  w_last;

    assign w_start_acc = (r_state == IDLE) && bus.start;
    assign w_w_acc     = w_w_ready && bus.w_valid;
    assign w_a_acc     = w_a_ready && bus.a_valid;
    assign w_last      = w_a_acc && (r_beat == r_num_pairs - 1'b1);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (bus.start) w_next = (bus.num_pairs == '0) ? DONE : WREQ;
            WREQ:  if (bus.w_valid) w_next = LWAIT;
            LWAIT: if (r_tmr == TMR_W'(ld_lat - 1)) w_next = EXEC;
            EXEC:  if (w_last) w_next = DRAIN;
            // The last execute is issued in the first DRAIN cycle, so DRAIN
            // spans exe_lat+1 cycles to place done right after the last psum.
            DRAIN: if (r_tmr == TMR_W'(exe_lat)) w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State-decoded outputs; readies never look at the valids
    always_comb begin
        w_w_ready = 1'b0;
        w_a_ready = 1'b0;
        w_busy    = 1'b1;
        w_done    = 1'b0;
        unique case (r_state)
            IDLE:    w_busy    = 1'b0;
            WREQ:    w_w_ready = 1'b1;
            EXEC:    w_a_ready = (r_beat < r_num_pairs);
            DONE:    w_done    = 1'b1;
            default: ;
        endcase
    end

    // Dwell timer for LWAIT and DRAIN, restarted on every state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmr <= '0;
        end else if (w_next != r_state) begin
            r_tmr <= '0;
        end else if ((r_state == LWAIT) || (r_state == DRAIN)) begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    // Command, weight and activation datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_num_pairs <= '0;
            r_beat      <= '0;
            r_weights   <= '0;
            r_mask      <= '0;
            r_act       <= '0;
            r_idx       <= '0;
            r_load      <= 1'b0;
            r_execute   <= 1'b0;
            r_a_select  <= 1'b0;
        end else begin
            r_load    <= w_w_acc;
            r_execute <= w_a_acc;
            if (w_start_acc) begin
                r_num_pairs <= bus.num_pairs;
                r_beat      <= '0;
            end
            if (w_w_acc) begin
                r_weights <= bus.w_data;
                r_mask    <= bus.w_mask;
            end
            if (w_a_acc) begin
                r_act      <= bus.a_data;
                r_idx      <= bus.a_index;
                r_a_select <= r_beat[0];
                r_beat     <= r_beat + 1'b1;
            end
        end
    end

    dp1m4_vdelay #(.DEPTH(exe_lat)) u_psum_dly (
        .clk   (clk),
        .reset (reset),
        .i_d   (r_execute),
        .o_q   (w_psum_valid)
    );

`ifdef DP1M4_ROW_SCHED_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_run_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_run_cnt   <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
            r_run_cnt   <= '0;
        end else begin
            if (w_a_ready && !bus.a_valid) r_stall_cnt <= sat_inc32(r_stall_cnt);
            if (w_busy)                    r_run_cnt   <= sat_inc32(r_run_cnt);
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.run_cnt   = r_run_cnt;
`endif

    assign bus.w_ready               = w_w_ready;
    assign bus.a_ready               = w_a_ready;
    assign bus.busy                  = w_busy;
    assign bus.done                  = w_done;
    assign bus.weights_flat          = r_weights;
    assign bus.weight_mask           = r_mask;
    assign bus.activation_flat       = r_act;
    assign bus.activation_index_flat = r_idx;
    assign bus.load                  = r_load;
    assign bus.execute               = r_execute;
    assign bus.a_select              = r_a_select;
    assign bus.psum_valid            = w_psum_valid;

endmodule

// File: tb/tb_dp1m4_row_sched.sv
// tb_dp1m4_row_sched: scoreboard bench for dp1m4_row_sched.
// Expected load/execute/psum_valid/done events are pushed when stimulus is
// driven and popped by a negedge monitor when the row signals fire.
module tb_dp1m4_row_sched;
    import dp1m4_pkg::*;

    localparam int BW      = 4;
    localparam int NNZ     = 8;
    localparam int TOTAL   = 16;
    localparam int CNT_W   = 16;
    localparam int EXE_LAT = 3;
    localparam int LD_LAT  = 2;

    typedef struct {
        int              c;
        logic            sel;
        logic [2*BW-1:0] act;
        logic [3:0]      idx;
    } exec_t;

    typedef struct {
        int                c;
        logic [NNZ*BW-1:0] wd;
        logic [TOTAL-1:0]  wm;
    } load_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    exec_t exec_q[$];
    load_t load_q[$];
    int    psum_q[$];
    int    done_q[$];

    exec_t m_ex;
    load_t m_ld;
    int    m_c;

    dp1m4_row_sched_if #(.bw(BW), .nnz(NNZ), .total(TOTAL), .cnt_w(CNT_W)) bus_if ();

    dp1m4_row_sched #(
        .bw(BW), .nnz(NNZ), .total(TOTAL), .cnt_w(CNT_W),
        .exe_lat(EXE_LAT), .ld_lat(LD_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_if.load) begin
                if (load_q.size() == 0) check("load_extra", 1, 0);
                else begin
                    m_ld = load_q.pop_front();
                    check("load_cycle", 64'(cyc), 64'(m_ld.c));
                    check("weights_flat", 64'(bus_if.weights_flat), 64'(m_ld.wd));
                    check("weight_mask", 64'(bus_if.weight_mask), 64'(m_ld.wm));
                end
            end
            if (bus_if.execute) begin
                if (exec_q.size() == 0) check("exec_extra", 1, 0);
                else begin
                    m_ex = exec_q.pop_front();
                    check("exec_cycle", 64'(cyc), 64'(m_ex.c));
                    check("a_select", 64'(bus_if.a_select), 64'(m_ex.sel));
                    check("activation_flat", 64'(bus_if.activation_flat), 64'(m_ex.act));
                    check("activation_index", 64'(bus_if.activation_index_flat), 64'(m_ex.idx));
                end
            end
            if (bus_if.psum_valid) begin
                if (psum_q.size() == 0) check("psum_extra", 1, 0);
                else begin
                    m_c = psum_q.pop_front();
                    check("psum_cycle", 64'(cyc), 64'(m_c));
                end
            end
            if (bus_if.done) begin
                if (done_q.size() == 0) check("done_extra", 1, 0);
                else begin
                    m_c = done_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(m_c));
                end
            end
        end
    end

    task automatic run_job(input int n, input int wdelay, input bit alt, input bit start_mid);
        int s, w, e0, b, last_e, done_c;
        bit fin;
        logic [NNZ*BW-1:0] wd;
        logic [TOTAL-1:0]  wm;
        exec_t ex;
        load_t ld;
        step();
        s = cyc;
        bus_if.start     = 1'b1;
        bus_if.num_pairs = CNT_W'(n);
        wd = (NNZ*BW)'($urandom);
        wm = TOTAL'($urandom);
        last_e = 0;
        if (n == 0) begin
            done_c = s + 1;
            done_q.push_back(done_c);
            step();
            bus_if.start     = 1'b0;
            bus_if.num_pairs = CNT_W'($urandom);
            bus_if.w_valid   = 1'b1;
            bus_if.w_data    = wd;
            @(negedge clk);
            check("w_ready_zero_job", 64'(bus_if.w_ready), 0);
            check("busy_zero_job", 64'(bus_if.busy), 1);
            step();
            bus_if.w_valid = 1'b0;
        end else begin
            w = s + 1 + wdelay;
            ld.c = w + 1; ld.wd = wd; ld.wm = wm;
            load_q.push_back(ld);
            step();
            bus_if.start     = 1'b0;
            bus_if.num_pairs = CNT_W'($urandom);
            fin = 1'b0;
            while (!fin) begin
                fin = (cyc == w);
                bus_if.w_valid = fin;
                bus_if.w_data  = fin ? wd : (NNZ*BW)'($urandom);
                bus_if.w_mask  = fin ? wm : TOTAL'($urandom);
                @(negedge clk);
                if (cyc == s + 1) begin
                    check("busy_running", 64'(bus_if.busy), 1);
                    check("w_ready_first", 64'(bus_if.w_ready), 1);
                end
                if (fin && wdelay > 0) check("w_ready_held", 64'(bus_if.w_ready), 1);
                step();
            end
            bus_if.w_valid = 1'b0;
            e0 = w + 1 + LD_LAT;
            b = 0;
            while (b < n) begin
                if (cyc >= e0 && (!alt || ((cyc - e0) % 2 == 0))) begin
                    bus_if.a_valid = 1'b1;
                    bus_if.a_data  = (2*BW)'($urandom);
                    bus_if.a_index = 4'($urandom);
                    ex.c   = cyc + 1;
                    ex.sel = b[0];
                    ex.act = bus_if.a_data;
                    ex.idx = bus_if.a_index;
                    exec_q.push_back(ex);
                    psum_q.push_back(cyc + 1 + EXE_LAT);
                    last_e = cyc + 1;
                    b++;
                end else begin
                    bus_if.a_valid = 1'b0;
                    bus_if.a_data  = (2*BW)'($urandom);
                end
                bus_if.start = start_mid && (cyc == e0 + 1);
                if (bus_if.start) bus_if.num_pairs = CNT_W'(7);
                step();
            end
            bus_if.a_valid = 1'b0;
            bus_if.start   = 1'b0;
            done_c = last_e + EXE_LAT + 1;
            done_q.push_back(done_c);
        end
        while (cyc < done_c + 1) step();
        @(negedge clk);
        check("busy_after_done", 64'(bus_if.busy), 0);
        check("load_q_empty", 64'(load_q.size()), 0);
        check("exec_q_empty", 64'(exec_q.size()), 0);
        check("psum_q_empty", 64'(psum_q.size()), 0);
        check("done_q_empty", 64'(done_q.size()), 0);
`ifdef DP1M4_ROW_SCHED_PERF_EN
        check("stall_cnt", 64'(bus_if.stall_cnt), alt ? 64'(n - 1) : 64'(0));
        check("run_cnt", 64'(bus_if.run_cnt), 64'(done_c - s));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({bus_if.w_ready, bus_if.a_ready, bus_if.load, bus_if.execute,
                                  bus_if.a_select, bus_if.psum_valid, bus_if.busy, bus_if.done}), 0);
        check({tag, "_data"}, 64'({bus_if.weights_flat, bus_if.weight_mask, bus_if.activation_flat,
                                   bus_if.activation_index_flat}), 0);
`ifdef DP1M4_ROW_SCHED_PERF_EN
        check({tag, "_perf"}, {bus_if.stall_cnt, bus_if.run_cnt}, 0);
`endif
    endtask

    // Abort a running 6-pair job with reset while the psum pipeline is full
    task automatic reset_mid();
        int s;
        mon_en = 1'b0;
        step();
        s = cyc;
        bus_if.start     = 1'b1;
        bus_if.num_pairs = CNT_W'(6);
        step();
        bus_if.start   = 1'b0;
        bus_if.w_valid = 1'b1;
        bus_if.w_data  = (NNZ*BW)'($urandom);
        step();
        bus_if.w_valid = 1'b0;
        bus_if.a_valid = 1'b1;
        while (cyc < s + 8) step();
        @(negedge clk);
        check("pre_reset_execute", 64'(bus_if.execute), 1);
        check("pre_reset_psum", 64'(bus_if.psum_valid), 1);
        step();
        reset = 1'b0;
        bus_if.a_valid = 1'b0;
        #1;
        check_all_zero("mid_reset");
        step();
        step();
        reset  = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k <= EXE_LAT; k++) begin
            @(negedge clk);
            check("psum_cleared", 64'(bus_if.psum_valid), 0);
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                = 1'b0;
        bus_if.start         = 1'b0;
        bus_if.num_pairs     = '0;
        bus_if.w_valid       = 1'b0;
        bus_if.w_data        = '0;
        bus_if.w_mask        = '0;
        bus_if.a_valid       = 1'b0;
        bus_if.a_data        = '0;
        bus_if.a_index       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        step();
        reset  = 1'b1;
        mon_en = 1'b1;

        run_job(5, 0, 1'b0, 1'b0);
        run_job(4, 0, 1'b1, 1'b0);
        run_job(3, 10, 1'b0, 1'b0);
        run_job(0, 0, 1'b0, 1'b0);
        run_job(5, 0, 1'b0, 1'b1);
        reset_mid();
        run_job(2, 0, 1'b0, 1'b0);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
